// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control unit. Walks each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath
// selects, write enables and ALU op; branch resolution uses ALU zf/sf.
module mc_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zf,
  input  logic       sf,
  output logic [2:0] alu_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state_q, state_d;

  // ALU op from funct3; MSB of the result flags a supported encoding.
  // Only R-type honours funct7b5 (sub); addi is always an add.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub);
    logic [3:0] r;
    case (f3)
      3'b000:  r = {1'b1, (sub ? 3'b010 : 3'b000)};
      3'b001,
      3'b100,
      3'b101,
      3'b110,
      3'b111:  r = {1'b1, f3};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Branch decision: {supported, take}. Signed compare uses sf alone.
  function automatic logic [1:0] br_dec(input logic [2:0] f3, input logic z, input logic s);
    logic [1:0] r;
    case (f3)
      3'b000:  r = {1'b1, z};
      3'b001:  r = {1'b1, ~z};
      3'b100:  r = {1'b1, s};
      3'b101:  r = {1'b1, ~s};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // State register with synchronous active-low reset to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // Next-state and output decode from state plus IR fields.
  always_comb begin
    logic [3:0] alu_r;
    logic [1:0] br_r;
    state_d    = FETCH;
    alu_sel    = 3'b000;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 3'b000;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    alu_r      = alu_dec(funct3, (state_q == EXECR) && funct7b5);
    br_r       = br_dec(funct3, zf, sf);

    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_IALU:           state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_STORE) begin
          imm_src = 3'b001;
          state_d = MEMWRITE;
        end else begin
          imm_src = 3'b000;
          state_d = MEMREAD;
        end
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR, EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_sel   = alu_r[2:0];
        if (alu_r[3]) state_d = ALUWB;
        else          illegal = 1'b1;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_sel   = 3'b010;
        pc_write  = br_r[1] & br_r[0];
        illegal   = ~br_r[1];
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase

    // In reset: FETCH selects, no writes, no illegal pulse.
    if (!rst_n) begin
      state_d    = FETCH;
      alu_sel    = 3'b000;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b10;
      imm_src    = 3'b000;
      result_src = 2'b10;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven bench for the multi-cycle control FSM.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zf = 1'b0;
  logic       sf = 1'b0;
  logic [2:0] alu_sel;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal;

  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zf(zf), .sf(sf), .alu_sel(alu_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  // {alu_sel, src_a, src_b, imm_src, result_src, adr_src, ir, pc, rw, mw, ill}
  function automatic logic [17:0] o(input logic [2:0] sel, input logic [1:0] a, input logic [1:0] b,
                                    input logic [2:0] imm, input logic [1:0] res, input logic adr,
                                    input logic ir, input logic pc, input logic rw, input logic mw,
                                    input logic ill);
    return {sel, a, b, imm, res, adr, ir, pc, rw, mw, ill};
  endfunction

  function automatic logic [17:0] e_execr(input logic [2:0] sel);
    return o(sel, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_execi(input logic [2:0] sel, input logic ill);
    return o(sel, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, ill);
  endfunction
  function automatic logic [17:0] e_br(input logic pc, input logic ill);
    return o(3'b010, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0, pc, 0, 0, ill);
  endfunction

  logic [17:0] E_RST, E_FET, E_DEC, E_DECI, E_MADL, E_MADS, E_MRD, E_MWB, E_MWR, E_AWB, E_JAL;

  wire [17:0] act = {alu_sel, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
                     ir_write, pc_write, reg_write, mem_write, illegal};

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zf;
    logic        sf;
    logic [17:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input logic s, input logic [17:0] e, input string nm);
    vec_t v;
    v.rst_n = r; v.op = op; v.f3 = f3; v.f7 = f7; v.zf = z; v.sf = s; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %05h want %05h", nm, got, want);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, compare once settled.
  task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic z, input logic s, input logic [17:0] e, input string nm);
    @(negedge clk);
    rst_n = r; opcode = op; funct3 = f3; funct7b5 = f7; zf = z; sf = s;
    #2;
    check(nm, act, e);
  endtask

  initial begin
    E_RST  = o(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0, 0, 0, 0, 0);
    E_FET  = o(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0);
    E_DEC  = o(3'b000, 2'b01, 2'b01, 3'b010, 2'b00, 0, 0, 0, 0, 0, 0);
    E_DECI = o(3'b000, 2'b01, 2'b01, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1);
    E_MADL = o(3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
    E_MADS = o(3'b000, 2'b10, 2'b01, 3'b001, 2'b00, 0, 0, 0, 0, 0, 0);
    E_MRD  = o(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0);
    E_MWB  = o(3'b000, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0, 1, 0, 0);
    E_MWR  = o(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1, 0);
    E_AWB  = o(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0);
    E_JAL  = o(3'b000, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0);

    // reset, then consecutive instructions (one vector per cycle)
    add(0, RT, 3'b000, 1, 0, 0, E_RST,            "rst0");
    add(0, RT, 3'b000, 1, 0, 0, E_RST,            "rst1");
    // sub
    add(1, RT, 3'b000, 1, 0, 0, E_FET,            "sub_fetch");
    add(1, RT, 3'b000, 1, 0, 0, E_DEC,            "sub_decode");
    add(1, RT, 3'b000, 1, 0, 0, e_execr(3'b010),  "sub_execr");
    add(1, RT, 3'b000, 1, 0, 0, E_AWB,            "sub_aluwb");
    // add
    add(1, RT, 3'b000, 0, 0, 0, E_FET,            "add_fetch");
    add(1, RT, 3'b000, 0, 0, 0, E_DEC,            "add_decode");
    add(1, RT, 3'b000, 0, 0, 0, e_execr(3'b000),  "add_execr");
    add(1, RT, 3'b000, 0, 0, 0, E_AWB,            "add_aluwb");
    // xor with funct7b5 set: funct7b5 only affects funct3=000
    add(1, RT, 3'b100, 1, 0, 0, E_FET,            "xor_fetch");
    add(1, RT, 3'b100, 1, 0, 0, E_DEC,            "xor_decode");
    add(1, RT, 3'b100, 1, 0, 0, e_execr(3'b100),  "xor_execr");
    add(1, RT, 3'b100, 1, 0, 0, E_AWB,            "xor_aluwb");
    // addi with funct7b5 set stays add
    add(1, IA, 3'b000, 1, 0, 0, E_FET,            "addi_fetch");
    add(1, IA, 3'b000, 1, 0, 0, E_DEC,            "addi_decode");
    add(1, IA, 3'b000, 1, 0, 0, e_execi(3'b000, 0), "addi_execi");
    add(1, IA, 3'b000, 1, 0, 0, E_AWB,            "addi_aluwb");
    // srli
    add(1, IA, 3'b101, 0, 0, 0, E_FET,            "srli_fetch");
    add(1, IA, 3'b101, 0, 0, 0, E_DEC,            "srli_decode");
    add(1, IA, 3'b101, 0, 0, 0, e_execi(3'b101, 0), "srli_execi");
    add(1, IA, 3'b101, 0, 0, 0, E_AWB,            "srli_aluwb");
    // load: 5 cycles
    add(1, LD, 3'b010, 0, 0, 0, E_FET,            "lw_fetch");
    add(1, LD, 3'b010, 0, 0, 0, E_DEC,            "lw_decode");
    add(1, LD, 3'b010, 0, 0, 0, E_MADL,           "lw_memadr");
    add(1, LD, 3'b010, 0, 0, 0, E_MRD,            "lw_memread");
    add(1, LD, 3'b010, 0, 0, 0, E_MWB,            "lw_memwb");
    // store: 4 cycles, mem_write only in the 4th
    add(1, ST, 3'b010, 0, 0, 0, E_FET,            "sw_fetch");
    add(1, ST, 3'b010, 0, 0, 0, E_DEC,            "sw_decode");
    add(1, ST, 3'b010, 0, 0, 0, E_MADS,           "sw_memadr");
    add(1, ST, 3'b010, 0, 0, 0, E_MWR,            "sw_memwrite");
    // branches: 3 cycles
    add(1, BR, 3'b000, 0, 1, 0, E_FET,            "beq1_fetch");
    add(1, BR, 3'b000, 0, 1, 0, E_DEC,            "beq1_decode");
    add(1, BR, 3'b000, 0, 1, 0, e_br(1, 0),       "beq_zf1");
    add(1, BR, 3'b000, 0, 0, 0, E_FET,            "beq0_fetch");
    add(1, BR, 3'b000, 0, 0, 0, E_DEC,            "beq0_decode");
    add(1, BR, 3'b000, 0, 0, 0, e_br(0, 0),       "beq_zf0");
    add(1, BR, 3'b001, 0, 0, 1, E_FET,            "bne_fetch");
    add(1, BR, 3'b001, 0, 0, 1, E_DEC,            "bne_decode");
    add(1, BR, 3'b001, 0, 0, 1, e_br(1, 0),       "bne_zf0");
    add(1, BR, 3'b100, 0, 1, 1, E_FET,            "blt_fetch");
    add(1, BR, 3'b100, 0, 1, 1, E_DEC,            "blt_decode");
    add(1, BR, 3'b100, 0, 1, 1, e_br(1, 0),       "blt_sf1");
    add(1, BR, 3'b101, 0, 0, 1, E_FET,            "bge1_fetch");
    add(1, BR, 3'b101, 0, 0, 1, E_DEC,            "bge1_decode");
    add(1, BR, 3'b101, 0, 0, 1, e_br(0, 0),       "bge_sf1");
    add(1, BR, 3'b101, 0, 1, 0, E_FET,            "bge0_fetch");
    add(1, BR, 3'b101, 0, 1, 0, E_DEC,            "bge0_decode");
    add(1, BR, 3'b101, 0, 1, 0, e_br(1, 0),       "bge_sf0");
    add(1, BR, 3'b010, 0, 1, 1, E_FET,            "brbad_fetch");
    add(1, BR, 3'b010, 0, 1, 1, E_DEC,            "brbad_decode");
    add(1, BR, 3'b010, 0, 1, 1, e_br(0, 1),       "brbad_branch");
    // illegal opcode: 2 cycles
    add(1, BAD, 3'b000, 0, 0, 0, E_FET,           "badop_fetch");
    add(1, BAD, 3'b000, 0, 0, 0, E_DECI,          "badop_decode");
    // slti unsupported: illegal in EXECI, no ALUWB
    add(1, IA, 3'b010, 0, 0, 0, E_FET,            "slti_fetch");
    add(1, IA, 3'b010, 0, 0, 0, E_DEC,            "slti_decode");
    add(1, IA, 3'b010, 0, 0, 0, e_execi(3'b000, 1), "slti_execi");
    // jal: 4 cycles
    add(1, JL, 3'b000, 0, 0, 0, E_FET,            "jal_fetch");
    add(1, JL, 3'b000, 0, 0, 0, E_DEC,            "jal_decode");
    add(1, JL, 3'b000, 0, 0, 0, E_JAL,            "jal_jal");
    add(1, JL, 3'b000, 0, 0, 0, E_AWB,            "jal_aluwb");
    add(1, RT, 3'b000, 0, 0, 0, E_FET,            "end_fetch");

    foreach (vecs[i])
      step(vecs[i].rst_n, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zf, vecs[i].sf,
           vecs[i].exp, vecs[i].name);

    // Reset held 2 clocks mid-MEMREAD abandons the load without writeback.
    step(1, LD, 3'b010, 0, 0, 0, E_DEC,  "rl_decode");
    step(1, LD, 3'b010, 0, 0, 0, E_MADL, "rl_memadr");
    step(1, LD, 3'b010, 0, 0, 0, E_MRD,  "rl_memread");
    step(0, LD, 3'b010, 0, 0, 0, E_RST,  "rl_rst0");
    step(0, LD, 3'b010, 0, 0, 0, E_RST,  "rl_rst1");
    step(1, LD, 3'b010, 0, 0, 0, E_FET,  "rl_release_fetch");
    step(1, LD, 3'b010, 0, 0, 0, E_DEC,  "rl_release_decode");

    // Reset during MEMWRITE suppresses the store.
    step(1, ST, 3'b010, 0, 0, 0, E_MADS, "rs_memadr");
    step(0, ST, 3'b010, 0, 0, 0, E_RST,  "rs_rst_memwrite");
    step(1, ST, 3'b010, 0, 0, 0, E_FET,  "rs_release_fetch");

    // Reset during an illegal DECODE masks the pulse.
    step(1, BAD, 3'b000, 0, 0, 0, E_DECI, "ri_decode");
    step(1, BAD, 3'b000, 0, 0, 0, E_FET,  "ri_fetch");
    step(0, BAD, 3'b000, 0, 0, 0, E_RST,  "ri_rst_decode");
    step(1, BAD, 3'b000, 0, 0, 0, E_FET,  "ri_release_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the RV32I core; it is the initiator on the ALU operation/flag interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Each state drives the datapath mux selects, write enables and the 3-bit ALU op select, and consumes the ALU zero/sign flags to resolve branches.
- Sits between the instruction register and the shared datapath (PC, memory, register file, ALU).

Parameters:
- RESET_STATE, 4'd0, encoding of FETCH, the state entered on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  IR[6:0], stable from DECODE onward
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zf  in  1  ALU zero flag
- sf  in  1  ALU sign flag (result bit 31)
- alu_sel  out  3  ALU op: 000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 register
- alu_src_b  out  2  00 rs2 register, 01 immext, 10 constant 4
- imm_src  out  3  000 I, 001 S, 010 B, 011 J
- result_src  out  2  00 ALU-out register, 01 memory data register, 10 ALU result
- adr_src  out  1  0 PC, 1 result
- ir_write  out  1  latch instruction and oldPC
- pc_write  out  1  PC update enable
- reg_write  out  1  register file write enable
- mem_write  out  1  data memory write enable
- illegal  out  1  one-cycle pulse on unsupported encoding

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- Reset: while rst_n=0 at a clock edge, state<=FETCH. Write enables (ir_write, pc_write, reg_write, mem_write) and illegal are forced 0 in any cycle where rst_n=0. Selects take their FETCH values. A reset mid-instruction abandons it with no further writes.
- Outputs are decoded combinationally from state plus opcode/funct fields. The only flag-dependent output is pc_write in BRANCH.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_sel=000, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=010, alu_sel=000 (branch target into ALU-out). Next state by opcode:
  - 0000011 (load) or 0100011 (store) -> MEMADR
  - 0110011 (R-type) -> EXECR
  - 0010011 (I-ALU) -> EXECI
  - 1100011 (branch) -> BRANCH
  - 1101111 (jal) -> JAL
  - any other opcode -> FETCH with illegal=1
- MEMADR: alu_src_a=10, alu_src_b=01, alu_sel=000. imm_src=000 for load, 001 for store. Next state is MEMREAD for load, MEMWRITE for store.
- MEMREAD: result_src=00, adr_src=1, then MEMWB. MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, then ALUWB. EXECI: alu_src_a=10, alu_src_b=01, imm_src=000, then ALUWB. ALU op mapping by funct3:
  - 000 -> 010 if EXECR and funct7b5=1, else 000 (addi is always add)
  - 001 -> 001, 100 -> 100, 101 -> 101, 110 -> 110, 111 -> 111
  - 010/011 (slt/sltu) -> illegal=1, next state FETCH, no writeback
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_sel=010, result_src=00. Then FETCH. pc_write by funct3:
  - 000 beq: zf
  - 001 bne: ~zf
  - 100 blt: sf
  - 101 bge: ~sf
  - other funct3: illegal=1, pc_write=0
  - Signed compare uses sf only; no overflow correction (decided).
- JAL: alu_src_a=01, alu_src_b=10, alu_sel=000, result_src=00, pc_write=1, then ALUWB.
- Latency (cycles): load 5; store 4; R/I-type 4; branch 3; jal 4; illegal 2.
- At most one of reg_write and mem_write is high in any cycle.
- Unreachable state encodings go to FETCH.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks mid-MEMREAD, then release -> state is FETCH, reg_write=0 and mem_write=0 throughout, ir_write=1 on the first cycle after release.
- R-type: opcode=0110011, funct3=000, funct7b5=1 -> sequence FETCH, DECODE, EXECR (alu_sel=010), ALUWB (reg_write=1), then FETCH. With funct7b5=0 -> alu_sel=000.
- Load: opcode=0000011 -> MEMADR (imm_src=000, alu_sel=000), MEMREAD (adr_src=1), MEMWB (result_src=01, reg_write=1); 5 cycles total. Store (0100011) -> mem_write=1 in the 4th cycle only.
- Branch: beq with zf=1 -> pc_write=1 in BRANCH; zf=0 -> pc_write=0. blt with sf=1 -> pc_write=1. bge with sf=1 -> pc_write=0.
- Illegal: opcode=0000000 -> illegal=1 in DECODE, then FETCH with no writes. I-type funct3=010 -> illegal=1 in EXECI, no ALUWB.
- JAL: opcode=1101111 -> JAL (pc_write=1, alu_src_b=10), ALUWB (reg_write=1), then FETCH.
